pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Lock supervisor and reset sequencer for the GTP_PLL_E3 clock generator. It runs on the PLL reference clock and synchronises the PLL `pll_lock` output, which is asynchronous to that clock. It holds the downstream logic in reset until lock has been stable for a programmable time. On loss of lock, or when lock never arrives, it drives a PLL reset pulse and retries, and it counts the relock attempts.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before reset is released; must be ≥ 1.
- `TIMEOUT_CYCLES`, default 65536: cycles spent in WAIT_LOCK before a PLL reset retry; must be ≥ 2. Only used with `PLL_LOCK_TIMEOUT_EN`.
- `RST_PULSE_CYCLES`, default 16: width of the `pll_rst` pulse in cycles; must be ≥ 1.
- `sys_clk` in 1: PLL reference clock (the 50 MHz board clock), not a PLL output.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `pll_lock` in 1: PLL LOCK output, asynchronous to `sys_clk`.
- `pll_rst` out 1: active-high reset to the PLL `RST` pin.
- `rst_out_n` out 1: active-low reset for logic clocked by the PLL outputs.
- `locked` out 1: high while in RUN.
- `lost_lock` out 1: one-cycle pulse when lock drops during RUN.
- `relock_cnt` out 8: saturating count of PLL reset retries.

## Operation
- Lock synchroniser:
  - Two flops clocked by `sys_clk`, reset to 0.
  - `lock_s` equals `pll_lock` delayed by 2 edges.
- Counter:
  - One shared counter, cleared on every state change.
  - Width is `$clog2` of the largest parameter in use.
- FSM states and transitions:
  - PLL_RST: `pll_rst`=1; counter counts up.
    - Counter == `RST_PULSE_CYCLES`-1 → WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1 → STABLE.
    - Otherwise, with the macro defined: counter == `TIMEOUT_CYCLES`-1 → PLL_RST and `relock_cnt`++.
  - STABLE:
    - `lock_s`=0 → WAIT_LOCK; `relock_cnt` is not incremented.
    - `lock_s`=1 with counter == `STABLE_CYCLES`-1 → RUN.
    - Otherwise the counter increments.
  - RUN: `rst_out_n`=1 and `locked`=1.
    - `lock_s`=0 → PLL_RST, `lost_lock`=1 for that single cycle, `relock_cnt`++.
- `relock_cnt` saturates at 255 and never wraps.
- All outputs are registered and change on the same edge as the state transition.
- `rst_out_n` and `locked` are high only in RUN. Both fall on the same edge that leaves RUN.
- Simultaneous events:
  - Timeout expiry and `lock_s`=1 in the same WAIT_LOCK cycle: lock wins, next state is STABLE, no increment.
  - A lock glitch inside STABLE restarts qualification from zero.

## Timing
- Reset values while `sys_rst_n`=0 (applied asynchronously):
  - state = PLL_RST, counter = 0;
  - `pll_rst`=1, `rst_out_n`=0, `locked`=0, `lost_lock`=0, `relock_cnt`=0, sync flops = 0.
- The first `pll_rst` pulse after reset release lasts `RST_PULSE_CYCLES` edges, counted from the first edge after release.
- Lock latency:
  - `lock_s` rises 2 edges after `pll_lock` is first sampled high.
  - `rst_out_n` rises `STABLE_CYCLES`+1 edges after `lock_s` rises.
  - End to end: `STABLE_CYCLES`+3 edges after `pll_lock` is first sampled high.
- Loss latency:
  - `pll_lock` low is synchronised in 2 edges.
  - The next edge enters PLL_RST: `rst_out_n`=0, `pll_rst`=1, `lost_lock`=1.
- Timeout: PLL_RST is entered `TIMEOUT_CYCLES` edges after entering WAIT_LOCK.
- Reset mid-operation: every output returns to its reset value immediately, without waiting for a clock edge, and the sequence restarts from PLL_RST.

## Configuration
- `PLL_LOCK_TIMEOUT_EN` defined:
  - The WAIT_LOCK timeout is active.
  - If the PLL never locks, it is retried every `TIMEOUT_CYCLES`+`RST_PULSE_CYCLES` cycles.
- `PLL_LOCK_TIMEOUT_EN` undefined:
  - WAIT_LOCK waits indefinitely.
  - `relock_cnt` increments only on loss of lock from RUN.
  - `TIMEOUT_CYCLES` is ignored and does not size the counter.

## Test plan
All scenarios use `STABLE_CYCLES`=8, `TIMEOUT_CYCLES`=32, `RST_PULSE_CYCLES`=4.
- Reset release with `pll_lock`=0 → `pll_rst` high for exactly 4 edges, then 0; `rst_out_n` stays 0.
- `pll_lock` rises and is held → `rst_out_n` and `locked` rise exactly 11 edges after `pll_lock` is first sampled high; `relock_cnt`=0.
- `pll_lock` low for 1 cycle at STABLE count 5 → return to WAIT_LOCK; after relock, `rst_out_n` rises 11 edges after the re-rise; no `relock_cnt` increment.
- In RUN, drop `pll_lock` → 3 edges later `lost_lock`=1 for one cycle, `rst_out_n`=0, `pll_rst`=1 for 4 cycles, `relock_cnt`=1.
- Macro defined, `pll_lock` held 0 → `pll_rst` pulses every 36 cycles; `relock_cnt` saturates at 255 after 255 retries. Macro undefined → a single pulse only.
- Assert `sys_rst_n` mid-RUN and mid-pulse → all outputs reach reset values before the next `sys_clk` edge; `relock_cnt`=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises pll_lock, qualifies it, sequences resets and retries.
// Optional WAIT_LOCK timeout with PLL reset retry is enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES   = 65536,
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       rst_out_n,
  output logic       locked,
  output logic       lost_lock,
  output logic [7:0] relock_cnt
);

  localparam int BASE_MAX = (STABLE_CYCLES > RST_PULSE_CYCLES) ? STABLE_CYCLES : RST_PULSE_CYCLES;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int CNT_MAX = (TIMEOUT_CYCLES > BASE_MAX) ? TIMEOUT_CYCLES : BASE_MAX;
`else
  localparam int CNT_MAX = BASE_MAX;
`endif
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  if (STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 2 || RST_PULSE_CYCLES < 1) begin : g_bad_param
    $error("pll_lock_supervisor: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [7:0]       relock_nx;
  logic             lost_nx;
  logic             lock_sync_p0;
  logic             lock_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_sync_p0 <= 1'b0;
      lock_s       <= 1'b0;
    end else begin
      lock_sync_p0 <= pll_lock;
      lock_s       <= lock_sync_p0;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNT_W'(1);
    relock_nx = relock_cnt;
    lost_nx   = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout expiry
        if (lock_s) begin
          state_nx = S_STABLE;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nx  = S_PLL_RST;
          relock_nx = sat_inc(relock_cnt);
        end
`else
        else begin
          cnt_nx = '0;
        end
`endif
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nx = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        cnt_nx = '0;
        if (!lock_s) begin
          state_nx  = S_PLL_RST;
          lost_nx   = 1'b1;
          relock_nx = sat_inc(relock_cnt);
        end
      end
      default: begin
        state_nx = S_PLL_RST;
      end
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  // Outputs are registered from the next state so they move on the transition edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_PLL_RST;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      rst_out_n  <= 1'b0;
      locked     <= 1'b0;
      lost_lock  <= 1'b0;
      relock_cnt <= 8'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pll_rst    <= (state_nx == S_PLL_RST);
      rst_out_n  <= (state_nx == S_RUN);
      locked     <= (state_nx == S_RUN);
      lost_lock  <= lost_nx;
      relock_cnt <= relock_nx;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with STABLE=8, TIMEOUT=32, RST_PULSE=4.
// Covers both PLL_LOCK_TIMEOUT_EN builds.
module tb_pll_lock_supervisor;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       pll_rst;
  logic       rst_out_n;
  logic       locked;
  logic       lost_lock;
  logic [7:0] relock_cnt;

  int total = 0;
  int bad   = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES   (8),
    .TIMEOUT_CYCLES  (32),
    .RST_PULSE_CYCLES(4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .rst_out_n (rst_out_n),
    .locked    (locked),
    .lost_lock (lost_lock),
    .relock_cnt(relock_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_rst_out_n"}, rst_out_n, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lost_lock"}, lost_lock, 0);
    chk({tag, "_relock_cnt"}, relock_cnt, 0);
  endtask

  initial begin
    int pulses;
    int exp_relock;
    sys_rst_n = 1'b0;
    pll_lock  = 1'b0;
    step(3);
    chk_reset_vals("reset");

    // Release: pll_rst high for 4 edges counted from the first edge after release
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk($sformatf("pulse_e%0d", i), pll_rst, (i < 4) ? 1 : 0);
    end
    step(10);
    chk("wait_pll_rst", pll_rst, 0);
    chk("wait_rst_out_n", rst_out_n, 0);

    // Lock with a one-cycle glitch at STABLE count 5
    pll_lock = 1'b1;
    step(6);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(1);
    step(1);
    chk("glitch_rst_out_n", rst_out_n, 0);
    chk("glitch_locked", locked, 0);
    step(8);
    chk("glitch_e10_rst_out_n", rst_out_n, 0);
    step(1);
    chk("glitch_e11_rst_out_n", rst_out_n, 1);
    chk("glitch_e11_locked", locked, 1);
    chk("glitch_relock_cnt", relock_cnt, 0);
    chk("glitch_pll_rst", pll_rst, 0);

    // Loss of lock from RUN
    step(3);
    pll_lock = 1'b0;
    step(1);
    chk("loss_e1_rst_out_n", rst_out_n, 1);
    step(1);
    chk("loss_e2_lost_lock", lost_lock, 0);
    chk("loss_e2_locked", locked, 1);
    step(1);
    chk("loss_e3_lost_lock", lost_lock, 1);
    chk("loss_e3_rst_out_n", rst_out_n, 0);
    chk("loss_e3_locked", locked, 0);
    chk("loss_e3_pll_rst", pll_rst, 1);
    chk("loss_e3_relock_cnt", relock_cnt, 1);
    step(1);
    chk("loss_e4_lost_lock", lost_lock, 0);
    chk("loss_e4_pll_rst", pll_rst, 1);
    step(2);
    chk("loss_e6_pll_rst", pll_rst, 1);
    step(1);
    chk("loss_e7_pll_rst", pll_rst, 0);

`ifdef PLL_LOCK_TIMEOUT_EN
    // Never locks: retry every 36 cycles, counter saturates at 255
    step(31);
    chk("to1_pre_pll_rst", pll_rst, 0);
    step(1);
    chk("to1_pll_rst", pll_rst, 1);
    chk("to1_relock_cnt", relock_cnt, 2);
    step(35);
    chk("to2_pre_pll_rst", pll_rst, 0);
    step(1);
    chk("to2_pll_rst", pll_rst, 1);
    chk("to2_relock_cnt", relock_cnt, 3);
    step(36 * 252);
    chk("sat_relock_cnt", relock_cnt, 255);
    chk("sat_pll_rst", pll_rst, 1);
    step(72);
    chk("sat_hold_relock_cnt", relock_cnt, 255);
    chk("sat_hold_pll_rst", pll_rst, 1);
    step(4);
    chk("sat_wait_pll_rst", pll_rst, 0);
    exp_relock = 255;
`else
    // No timeout: a single pulse only
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (pll_rst) pulses++;
    end
    chk("no_timeout_pulses", pulses, 0);
    chk("no_timeout_relock_cnt", relock_cnt, 1);
    exp_relock = 1;
`endif

    // Clean relock: rise exactly 11 edges after pll_lock is first sampled high
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step(1);
      chk($sformatf("relock_e%0d_rst_out_n", i), rst_out_n, (i >= 11) ? 1 : 0);
    end
    chk("relock_locked", locked, 1);
    chk("relock_relock_cnt", relock_cnt, exp_relock);

    // Asynchronous reset mid-RUN
    step(2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_run");

    // Asynchronous reset in the pulse right after a loss
    step(1);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 50 && !locked; k++) step(1);
    chk("rst2_wait_locked", locked, 1);
    pll_lock = 1'b0;
    step(3);
    chk("rst2_lost_lock", lost_lock, 1);
    chk("rst2_relock_cnt", relock_cnt, 1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_pulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
